tone_detector: RTL and testbench

- Receive-side counterpart of the square-wave note oscillator: measures the half-period of an incoming 1-bit audio square wave and decodes which of four notes (F#5, A5, C#6, E6) is present.
- Sits on the input path from an external/looped-back tone source. Reports a stable 2-bit note code with a valid flag, plus the raw half-period measurement for debug.

---
 rtl/tone_detector.sv | 189 ++++++++++++++++++
 tb/tb_tone_detector.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_detector.sv
// Measures the half-period of a 1-bit square wave and decodes which of four notes
// is present, with a lock streak, loss-of-signal timeout and raw period debug output.
module tone_detector #(
    parameter int unsigned NOM0       = 13514,
    parameter int unsigned NOM1       = 11363,
    parameter int unsigned NOM2       = 9020,
    parameter int unsigned NOM3       = 7584,
    parameter int unsigned TOL        = 256,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned TIMEOUT    = 20000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        AUDIO_IN,
    output logic [1:0]  NOTE_OUT,
    output logic        NOTE_VALID,
    output logic [15:0] PERIOD_OUT,
    output logic        PERIOD_STB
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [31:0] LO0       = NOM0 - TOL;
    localparam logic [31:0] HI0       = NOM0 + TOL;
    localparam logic [31:0] LO1       = NOM1 - TOL;
    localparam logic [31:0] HI1       = NOM1 + TOL;
    localparam logic [31:0] LO2       = NOM2 - TOL;
    localparam logic [31:0] HI2       = NOM2 + TOL;
    localparam logic [31:0] LO3       = NOM3 - TOL;
    localparam logic [31:0] HI3       = NOM3 + TOL;
    localparam logic [31:0] TIMEOUT_W = TIMEOUT;
    localparam logic [3:0]  LOCK_W    = LOCK_COUNT[3:0];

    // Returns {hit, note index}; 32-bit ordered range checks so nothing can wrap.
    function automatic logic [2:0] classify(input logic [15:0] cap);
        logic [31:0] c;
        c = {16'd0, cap};
        if (c >= LO0 && c <= HI0) begin
            classify = 3'b100;
        end else if (c >= LO1 && c <= HI1) begin
            classify = 3'b101;
        end else if (c >= LO2 && c <= HI2) begin
            classify = 3'b110;
        end else if (c >= LO3 && c <= HI3) begin
            classify = 3'b111;
        end else begin
            classify = 3'b000;
        end
    endfunction

    logic        sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [15:0] counter_q, counter_d;
    state_t      state_q, state_d;
    logic [1:0]  cand_q, cand_d;
    logic [3:0]  streak_q, streak_d;
    logic [1:0]  note_q, note_d;
    logic        valid_q, valid_d;
    logic [15:0] period_q, period_d;
    logic        stb_q, stb_d;

    logic        edge_s;
    logic        timeout_s;
    logic [15:0] cap_s;
    logic [2:0]  class_s;
    logic        hit_s;
    logic [1:0]  idx_s;
    logic [3:0]  streak_n_s;

    assign edge_s    = sync2_q ^ sync3_q;
    assign timeout_s = ({16'd0, counter_q} >= TIMEOUT_W);
    assign cap_s     = (counter_q == 16'hFFFF) ? 16'hFFFF : (counter_q + 16'd1);
    assign class_s   = classify(cap_s);
    assign hit_s     = class_s[2];
    assign idx_s     = class_s[1:0];

    // Synchroniser chain and saturating half-period counter next-state.
    always_comb begin
        sync1_d = AUDIO_IN;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        if (edge_s) begin
            counter_d = 16'd0;
        end else if (counter_q != 16'hFFFF) begin
            counter_d = counter_q + 16'd1;
        end else begin
            counter_d = counter_q;
        end
    end

    // Lock FSM next-state and output register inputs.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        streak_d   = streak_q;
        note_d     = note_q;
        valid_d    = valid_q;
        period_d   = period_q;
        stb_d      = 1'b0;
        streak_n_s = 4'd1;
        case (state_q)
            ST_IDLE: begin
                if (edge_s) begin
                    state_d = ST_MEASURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEASURE, ST_LOCKED: begin
                if (edge_s) begin
                    period_d = cap_s;
                    stb_d    = 1'b1;
                    if (hit_s && state_q == ST_LOCKED && idx_s == note_q) begin
                        state_d = ST_LOCKED;
                    end else if (hit_s) begin
                        if (state_q == ST_MEASURE && idx_s == cand_q) begin
                            streak_n_s = streak_q + 4'd1;
                        end else begin
                            streak_n_s = 4'd1;
                        end
                        cand_d   = idx_s;
                        streak_d = streak_n_s;
                        if (streak_n_s >= LOCK_W) begin
                            state_d = ST_LOCKED;
                            note_d  = idx_s;
                            valid_d = 1'b1;
                        end else begin
                            state_d = ST_MEASURE;
                            valid_d = 1'b0;
                        end
                    end else begin
                        state_d  = ST_MEASURE;
                        valid_d  = 1'b0;
                        streak_d = 4'd0;
                    end
                end else if (timeout_s) begin
                    state_d  = ST_IDLE;
                    valid_d  = 1'b0;
                    streak_d = 4'd0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                valid_d  = 1'b0;
                streak_d = 4'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            counter_q <= 16'd0;
            state_q   <= ST_IDLE;
            cand_q    <= 2'd0;
            streak_q  <= 4'd0;
            note_q    <= 2'd0;
            valid_q   <= 1'b0;
            period_q  <= 16'd0;
            stb_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            counter_q <= counter_d;
            state_q   <= state_d;
            cand_q    <= cand_d;
            streak_q  <= streak_d;
            note_q    <= note_d;
            valid_q   <= valid_d;
            period_q  <= period_d;
            stb_q     <= stb_d;
        end
    end

    assign NOTE_OUT   = note_q;
    assign NOTE_VALID = valid_q;
    assign PERIOD_OUT = period_q;
    assign PERIOD_STB = stb_q;

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector with periods scaled down (NOMk/100, TOL 2,
// TIMEOUT 200) so every scenario fits in a short run.
module tb_tone_detector;

    localparam int NOM0 = 135;
    localparam int NOM1 = 113;
    localparam int NOM2 = 90;
    localparam int NOM3 = 75;
    localparam int TOL  = 2;
    localparam int TMO  = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        audio = 1'b0;
    logic [1:0]  note_out;
    logic        note_valid;
    logic [15:0] period_out;
    logic        period_stb;

    int checks = 0;
    int passed = 0;
    int since = 0;
    int stb_cnt = 0;
    int snap;

    typedef struct {
        int half;
        int n;
        int exp_period;
        int exp_valid;
        int exp_note;
        int exp_stb;
    } vec_t;

    vec_t vecs [9];

    tone_detector #(
        .NOM0(NOM0), .NOM1(NOM1), .NOM2(NOM2), .NOM3(NOM3),
        .TOL(TOL), .LOCK_COUNT(4), .TIMEOUT(TMO)
    ) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .AUDIO_IN(audio),
        .NOTE_OUT(note_out),
        .NOTE_VALID(note_valid),
        .PERIOD_OUT(period_out),
        .PERIOD_STB(period_stb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (period_stb) stb_cnt = stb_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act == exp) passed = passed + 1;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
        since = since + n;
    endtask

    // Wait so that this toggle lands h cycles after the previous one.
    task automatic half(input int h);
        wait_cyc(h - since);
        audio = ~audio;
        since = 0;
    endtask

    task automatic reference();
        audio = ~audio;
        since = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        audio = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        since = 0;
        stb_cnt = 0;
    endtask

    task automatic lock_on(input int h);
        do_reset();
        reference();
        repeat (4) half(h);
        wait_cyc(3);
    endtask

    initial begin
        vecs[0] = '{NOM1,       5, NOM1,       1, 1, 5};
        vecs[1] = '{NOM1,       3, NOM1,       0, 0, 3};
        vecs[2] = '{NOM2 + TOL, 4, NOM2 + TOL, 1, 2, 4};
        vecs[3] = '{NOM2 + TOL + 1, 7, NOM2 + TOL + 1, 0, 0, 7};
        vecs[4] = '{NOM2 - TOL, 4, NOM2 - TOL, 1, 2, 4};
        vecs[5] = '{NOM0,       4, NOM0,       1, 0, 4};
        vecs[6] = '{NOM3,       5, NOM3,       1, 3, 5};
        vecs[7] = '{NOM0 - 2,   4, NOM0 - 2,   1, 0, 4};
        vecs[8] = '{50,         5, 50,         0, 0, 5};

        // Reset held while the input toggles.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            audio = ~audio;
            wait_cyc(7);
        end
        chk("rst_note", int'(note_out), 0);
        chk("rst_valid", int'(note_valid), 0);
        chk("rst_period", int'(period_out), 0);
        chk("rst_stb", int'(period_stb), 0);
        audio = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
        stb_cnt = 0;
        reference();
        wait_cyc(10);
        chk("first_edge_no_stb", stb_cnt, 0);
        chk("first_edge_no_period", int'(period_out), 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            reference();
            for (int j = 0; j < vecs[i].n; j++) half(vecs[i].half);
            wait_cyc(3);
            chk($sformatf("vec%0d_period", i), int'(period_out), vecs[i].exp_period);
            chk($sformatf("vec%0d_valid", i), int'(note_valid), vecs[i].exp_valid);
            chk($sformatf("vec%0d_note", i), int'(note_out), vecs[i].exp_note);
            wait_cyc(1);
            chk($sformatf("vec%0d_stb", i), stb_cnt, vecs[i].exp_stb);
        end

        // Lock latency: valid exactly 3 cycles after the 5th raw edge.
        do_reset();
        reference();
        repeat (4) half(NOM1);
        wait_cyc(2);
        chk("lat_valid_early", int'(note_valid), 0);
        wait_cyc(1);
        chk("lat_valid", int'(note_valid), 1);
        chk("lat_note", int'(note_out), 1);

        // Note change from 0 to 3.
        lock_on(NOM0);
        chk("sw_lock0_valid", int'(note_valid), 1);
        chk("sw_lock0_note", int'(note_out), 0);
        half(NOM3);
        wait_cyc(3);
        chk("sw_drop_valid", int'(note_valid), 0);
        chk("sw_hold_note", int'(note_out), 0);
        chk("sw_period", int'(period_out), NOM3);
        repeat (2) half(NOM3);
        wait_cyc(3);
        chk("sw_third_valid", int'(note_valid), 0);
        half(NOM3);
        wait_cyc(3);
        chk("sw_relock_valid", int'(note_valid), 1);
        chk("sw_relock_note", int'(note_out), 3);

        // Loss of signal then restart.
        lock_on(NOM1);
        wait_cyc(TMO + 3 - since);
        chk("tmo_before", int'(note_valid), 1);
        wait_cyc(1);
        chk("tmo_after", int'(note_valid), 0);
        chk("tmo_note_hold", int'(note_out), 1);
        wait_cyc(100);
        snap = stb_cnt;
        reference();
        wait_cyc(10);
        chk("tmo_ref_no_stb", stb_cnt - snap, 0);
        repeat (3) half(NOM1);
        wait_cyc(3);
        chk("tmo_three_valid", int'(note_valid), 0);
        half(NOM1);
        wait_cyc(3);
        chk("tmo_relock_valid", int'(note_valid), 1);
        chk("tmo_relock_note", int'(note_out), 1);

        // Stray short pulse, then reset mid-measurement.
        lock_on(NOM1);
        half(50);
        wait_cyc(3);
        chk("stray_valid", int'(note_valid), 0);
        chk("stray_period", int'(period_out), 50);
        chk("stray_note", int'(note_out), 1);
        repeat (2) half(NOM1);
        wait_cyc(5);
        rst_n = 1'b0;
        #1;
        chk("arst_note", int'(note_out), 0);
        chk("arst_valid", int'(note_valid), 0);
        chk("arst_period", int'(period_out), 0);
        audio = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
        stb_cnt = 0;
        reference();
        repeat (3) half(NOM1);
        wait_cyc(3);
        chk("arst_three_valid", int'(note_valid), 0);
        half(NOM1);
        wait_cyc(3);
        chk("arst_relock_valid", int'(note_valid), 1);
        chk("arst_relock_note", int'(note_out), 1);
        wait_cyc(1);
        chk("arst_relock_stb", stb_cnt, 4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
